// File: rtl/sr_flag_pkg.sv
// rtl/sr_flag_pkg.sv - shared op constants and FSM state encoding for sr_flag_arbiter
package sr_flag_pkg;

  localparam logic OP_CLEAR = 1'b0;
  localparam logic OP_SET   = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

endpackage

// File: rtl/sr_flag_arbiter_rr_pick.sv
// rtl/sr_flag_arbiter_rr_pick.sv - combinational round-robin picker
// Grants the first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any_gnt
);

  logic [IDW-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IDW'((int'(ptr) + k) % N);
      if (!any_gnt && req[j]) begin
        any_gnt = 1'b1;
        gnt[j]  = 1'b1;
        gnt_id  = j;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin serialized set/clear access to a shared flag bank
// Optional per-flag ownership checking is enabled by defining SR_FLAG_OWNER_EN.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_err,
  output logic [NFLAG-1:0]     flags,
  output logic                 busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               op_q, op_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [NFLAG-1:0]   flags_q, flags_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [NREQ-1:0]    err_q, err_d;
`ifdef SR_FLAG_OWNER_EN
  logic [NFLAG-1:0][IDW-1:0] owner_q, owner_d;
`endif

  logic [IDXW-1:0] idx_arr [NREQ];
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            any_gnt;
  logic            in_range;

  for (genvar i = 0; i < NREQ; i++) begin : g_idx
    assign idx_arr[i] = req_idx[i*IDXW +: IDXW];
  end

  // A requester is masked during its ack cycle so its stale valid is not re-granted.
  assign eligible = req_valid & ~ack_q;
  assign in_range = ({1'b0, idx_q} < (IDXW+1)'(NFLAG));

  rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (any_gnt)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    idx_d    = idx_q;
    flags_d  = flags_q;
    ack_d    = '0;
    err_d    = '0;
`ifdef SR_FLAG_OWNER_EN
    owner_d  = owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_gnt) begin
          id_d    = gnt_id;
          op_d    = req_op[gnt_id];
          idx_d   = idx_arr[gnt_id];
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        ack_d[id_q] = 1'b1;
        rr_ptr_d    = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
        state_d     = ST_IDLE;
        if (!in_range) begin
          err_d[id_q] = 1'b1;
        end else begin
`ifdef SR_FLAG_OWNER_EN
          if (op_q == OP_SET) begin
            if (!flags_q[idx_q]) begin
              flags_d[idx_q] = 1'b1;
              owner_d[idx_q] = id_q;
            end else if (owner_q[idx_q] != id_q) begin
              err_d[id_q] = 1'b1;
            end
          end else if (flags_q[idx_q]) begin
            // Clearing an already-clear flag is a harmless no-op for anyone.
            if (owner_q[idx_q] == id_q) begin
              flags_d[idx_q] = 1'b0;
              owner_d[idx_q] = '0;
            end else begin
              err_d[id_q] = 1'b1;
            end
          end
`else
          flags_d[idx_q] = (op_q == OP_SET);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_q     <= OP_CLEAR;
      idx_q    <= '0;
      flags_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
`ifdef SR_FLAG_OWNER_EN
      owner_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      flags_q  <= flags_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
`ifdef SR_FLAG_OWNER_EN
      owner_q  <= owner_d;
`endif
    end
  end

  assign req_ack = ack_q;
  assign req_err = err_q;
  assign flags   = flags_q;
  assign busy    = (state_q == ST_APPLY);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed self-checking bench for sr_flag_arbiter
// Second instance with NFLAG=6 covers the out-of-range index path.
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  valid = '0, op = '0;
  logic [11:0] idx = '0;
  logic [3:0]  ack, err;
  logic [7:0]  flags;
  logic        busy;

  logic [3:0]  valid6 = '0, op6 = '0;
  logic [11:0] idx6 = '0;
  logic [3:0]  ack6, err6;
  logic [5:0]  flags6;
  logic        busy6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) u_dut (
    .clk(clk), .reset(reset), .req_valid(valid), .req_op(op), .req_idx(idx),
    .req_ack(ack), .req_err(err), .flags(flags), .busy(busy)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) u_dut6 (
    .clk(clk), .reset(reset), .req_valid(valid6), .req_op(op6), .req_idx(idx6),
    .req_ack(ack6), .req_err(err6), .flags(flags6), .busy(busy6)
  );

  task automatic post(input int i, input logic o, input logic [2:0] x);
    valid[i] = 1'b1;
    op[i] = o;
    idx[i*3 +: 3] = x;
  endtask

  task automatic do_reset();
    valid = '0; valid6 = '0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (flags !== 8'h00) begin failures++; $display("FAIL reset_flags got=%h exp=00", flags); end
    checks++; if (ack !== 4'h0) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    post(0, 1'b1, 3'd3);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_pre got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_async_busy got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (ack !== 4'h0) begin failures++; $display("FAIL midreset_ack got=%b exp=0000", ack); end
    checks++; if (flags !== 8'h00) begin failures++; $display("FAIL midreset_flags got=%h exp=00", flags); end
    valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_set();
    do_reset();
    post(0, 1'b1, 3'd3);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ack !== 4'h0) begin failures++; $display("FAIL single_busy got=%b/%b exp=1/0000", busy, ack); end
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", ack); end
    checks++; if (err !== 4'h0) begin failures++; $display("FAIL single_err got=%b exp=0000", err); end
    checks++; if (flags !== 8'h08) begin failures++; $display("FAIL single_flags got=%h exp=08", flags); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b/%b exp=0000/0", ack, busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) post(i, 1'b1, 3'(i));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checks++; if (ack !== 4'h0) begin failures++; $display("FAIL rr_gap r=%0d k=%0d got=%b exp=0000", r, k, ack); end
        @(negedge clk);
        checks++; if (ack !== 4'(1 << k)) begin failures++; $display("FAIL rr_order r=%0d k=%0d got=%b exp=%b", r, k, ack, 4'(1 << k)); end
        valid[k] = 1'b0;
      end
      checks++; if (flags !== 8'h0F) begin failures++; $display("FAIL rr_flags r=%0d got=%h exp=0F", r, flags); end
    end
  endtask

  task automatic test_set_clear_race();
    do_reset();
    post(1, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL race_prep_ack got=%b exp=0010", ack); end
    valid[1] = 1'b0;
    @(negedge clk);
    post(1, 1'b1, 3'd5);
    post(2, 1'b0, 3'd5);
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL race_first got=%b exp=0100", ack); end
    valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL race_second got=%b exp=0010", ack); end
    checks++; if (flags !== 8'h20) begin failures++; $display("FAIL race_flags got=%h exp=20", flags); end
    valid[1] = 1'b0;
  endtask

  task automatic test_out_of_range();
    do_reset();
    valid6[0] = 1'b1; op6[0] = 1'b1; idx6[2:0] = 3'd7;
    repeat (2) @(negedge clk);
    checks++; if (ack6 !== 4'b0001 || err6 !== 4'b0001) begin failures++; $display("FAIL oor_ack_err got=%b/%b exp=0001/0001", ack6, err6); end
    checks++; if (flags6 !== 6'h00) begin failures++; $display("FAIL oor_flags got=%h exp=00", flags6); end
    valid6[0] = 1'b0;
    @(negedge clk);
    valid6[0] = 1'b1; idx6[2:0] = 3'd5;
    repeat (2) @(negedge clk);
    checks++; if (ack6 !== 4'b0001 || err6 !== 4'b0000) begin failures++; $display("FAIL edge_ack_err got=%b/%b exp=0001/0000", ack6, err6); end
    checks++; if (flags6 !== 6'h20) begin failures++; $display("FAIL edge_flags got=%h exp=20", flags6); end
    valid6[0] = 1'b0;
  endtask

  task automatic test_owner();
    logic [3:0] exp_err;
    logic [7:0] exp_flags;
`ifdef SR_FLAG_OWNER_EN
    exp_err = 4'b0010; exp_flags = 8'h04;
`else
    exp_err = 4'b0000; exp_flags = 8'h00;
`endif
    do_reset();
    post(0, 1'b1, 3'd2);
    repeat (2) @(negedge clk);
    checks++; if (flags !== 8'h04 || err !== 4'h0) begin failures++; $display("FAIL own_set got=%h/%b exp=04/0000", flags, err); end
    valid[0] = 1'b0;
    @(negedge clk);
    post(1, 1'b0, 3'd2);
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0010 || err !== exp_err) begin failures++; $display("FAIL own_other_clear got=%b/%b exp=0010/%b", ack, err, exp_err); end
    checks++; if (flags !== exp_flags) begin failures++; $display("FAIL own_other_flags got=%h exp=%h", flags, exp_flags); end
    valid[1] = 1'b0;
    @(negedge clk);
    post(0, 1'b0, 3'd2);
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0001 || err !== 4'h0) begin failures++; $display("FAIL own_clear got=%b/%b exp=0001/0000", ack, err); end
    checks++; if (flags !== 8'h00) begin failures++; $display("FAIL own_clear_flags got=%h exp=00", flags); end
    valid[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_set_clear_race();
    test_out_of_range();
    test_owner();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
